// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode field width, opcode encodings and the
// arbiter FSM state encoding.
package alu_pkg;

    localparam int unsigned OP_W = 5;

    localparam logic [OP_W-1:0] OP_ADD   = 5'b00001;
    localparam logic [OP_W-1:0] OP_NEG   = 5'b00010;
    localparam logic [OP_W-1:0] OP_SUB   = 5'b00011;
    localparam logic [OP_W-1:0] OP_MUL   = 5'b00100;
    localparam logic [OP_W-1:0] OP_CMP   = 5'b00101;
    localparam logic [OP_W-1:0] OP_DIV   = 5'b01000;
    localparam logic [OP_W-1:0] OP_REM   = 5'b01001;
    localparam logic [OP_W-1:0] OP_AND   = 5'b01010;
    localparam logic [OP_W-1:0] OP_NOT   = 5'b01011;
    localparam logic [OP_W-1:0] OP_OR    = 5'b01100;
    localparam logic [OP_W-1:0] OP_XOR   = 5'b01101;
    localparam logic [OP_W-1:0] OP_SLL   = 5'b01110;
    localparam logic [OP_W-1:0] OP_SRL   = 5'b01111;
    localparam logic [OP_W-1:0] OP_SRA   = 5'b10000;
    localparam logic [OP_W-1:0] OP_PASSB = 5'b11000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// 2-way round-robin selector.
//   req_valid  in  2  per-port request valid
//   last_grant in  1  port granted most recently
//   sel        out 1  selected port (only meaningful when its req_valid is set)
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       last_grant,
    output logic       sel
);

    // With contention the port that did not win last time goes next.
    always_comb begin
        sel = ~last_grant;
        case (req_valid)
            2'b01:   sel = 1'b0;
            2'b10:   sel = 1'b1;
            2'b11:   sel = ~last_grant;
            default: sel = ~last_grant;
        endcase
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one registered ALU between the execute stage (port 0) and the
// branch/compare unit (port 1). One op in flight; div/rem by zero and ALU
// timeout are answered locally with rsp_err.
//   clk, rst (sync, active-high)
//   req_valid/req_ready[1:0], req{0,1}_op/a/b : request channels
//   rsp_valid[1:0], rsp_data, rsp_err          : response channels
//   alu_en/op/a/b out, alu_valid/data in       : ALU interface
//   busy, grant_id                             : status
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned OP_W    = alu_pkg::OP_W,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OP_W-1:0]  req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OP_W-1:0]  req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [1:0]       rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             alu_en,
    output logic [OP_W-1:0]  alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic             alu_valid,
    input  logic [WIDTH-1:0] alu_data,
    output logic             busy,
    output logic             grant_id
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             last_grant, last_grant_nxt;
    logic             sel;
    logic             accept;
    logic             div_zero;
    logic [OP_W-1:0]  sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;

    logic             grant_nxt, alu_en_nxt, rsp_err_nxt, busy_nxt;
    logic [1:0]       rsp_valid_nxt;
    logic [OP_W-1:0]  alu_op_nxt;
    logic [WIDTH-1:0] alu_a_nxt, alu_b_nxt, rsp_data_nxt;

    rr_arb2 u_arb (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .sel        (sel)
    );

    // Selected request payload and handshake.
    assign sel_op   = sel ? req1_op : req0_op;
    assign sel_a    = sel ? req1_a  : req0_a;
    assign sel_b    = sel ? req1_b  : req0_b;
    assign accept   = !rst && (state == S_IDLE) && req_valid[sel];
    assign req_ready = {accept && sel, accept && !sel};
    assign div_zero = ((sel_op == OP_W'(OP_DIV)) || (sel_op == OP_W'(OP_REM)))
                      && (sel_b == '0);

    // Next-state and next-output logic.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        grant_nxt      = grant_id;
        alu_en_nxt     = 1'b0;
        alu_op_nxt     = alu_op;
        alu_a_nxt      = alu_a;
        alu_b_nxt      = alu_b;
        rsp_valid_nxt  = 2'b00;
        rsp_data_nxt   = rsp_data;
        rsp_err_nxt    = rsp_err;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    alu_op_nxt     = sel_op;
                    alu_a_nxt      = sel_a;
                    alu_b_nxt      = sel_b;
                    grant_nxt      = sel;
                    last_grant_nxt = sel;
                    if (div_zero) begin
                        state_nxt     = S_RESP;
                        rsp_valid_nxt = {sel, !sel};
                        rsp_data_nxt  = '0;
                        rsp_err_nxt   = 1'b1;
                    end else begin
                        state_nxt  = S_ISSUE;
                        alu_en_nxt = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
                cnt_nxt   = '0;
            end
            S_WAIT: begin
                // Counter reaches TIMEOUT-1 on the edge that gives up.
                cnt_nxt = cnt + 1'b1;
                if (alu_valid) begin
                    state_nxt     = S_RESP;
                    rsp_valid_nxt = {grant_id, !grant_id};
                    rsp_data_nxt  = alu_data;
                    rsp_err_nxt   = 1'b0;
                end else if (cnt == CNT_W'(TIMEOUT - 2)) begin
                    state_nxt     = S_RESP;
                    rsp_valid_nxt = {grant_id, !grant_id};
                    rsp_data_nxt  = '0;
                    rsp_err_nxt   = 1'b1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            alu_en     <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 2'b00;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= last_grant_nxt;
            grant_id   <= grant_nxt;
            alu_en     <= alu_en_nxt;
            alu_op     <= alu_op_nxt;
            alu_a      <= alu_a_nxt;
            alu_b      <= alu_b_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_data   <= rsp_data_nxt;
            rsp_err    <= rsp_err_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter with a one-cycle registered ALU model.
module tb_alu_req_arbiter;
    import alu_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned OPW = 5;
    localparam int unsigned TO  = 8;

    logic           clk, rst;
    logic [1:0]     req_valid, req_ready, rsp_valid;
    logic [OPW-1:0] req0_op, req1_op, alu_op;
    logic [W-1:0]   req0_a, req0_b, req1_a, req1_b, rsp_data, alu_a, alu_b, alu_data;
    logic           rsp_err, alu_en, alu_valid, busy, grant_id;

    logic           mdl_valid, alu_attached, force_valid;
    logic [W-1:0]   mdl_data, force_data;

    int errors = 0;
    int checks = 0;

    alu_req_arbiter #(.WIDTH(W), .OP_W(OPW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_valid(alu_valid), .alu_data(alu_data),
        .busy(busy), .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_model(input logic [OPW-1:0] op,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            OP_ADD:   return a + b;
            OP_SUB:   return a - b;
            OP_MUL:   return a * b;
            OP_DIV:   return (b != 0) ? a / b : '0;
            OP_REM:   return (b != 0) ? a % b : '0;
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_XOR:   return a ^ b;
            OP_NOT:   return ~a;
            OP_PASSB: return b;
            default:  return '0;
        endcase
    endfunction

    // Registered ALU: result one cycle after alu_en, when attached.
    always @(posedge clk) begin
        if (rst) mdl_valid <= 1'b0;
        else     mdl_valid <= alu_en & alu_attached;
        mdl_data <= alu_model(alu_op, alu_a, alu_b);
    end
    assign alu_valid = mdl_valid | force_valid;
    assign alu_data  = force_valid ? force_data : mdl_data;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic           port;
        logic [OPW-1:0] op;
        logic [W-1:0]   a, b, exp_data;
        logic           exp_err;
        int             exp_lat;
        int             exp_en;
    } vec_t;

    vec_t vecs[8];

    int           r_lat, r_en, r_busy_low;
    logic [W-1:0] r_data;
    logic         r_err;
    logic [1:0]   r_bits, r_after;

    // One request on one port; lat counts cycles after the acceptance edge.
    task automatic run_one(input logic port, input logic [OPW-1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input int inj, input logic [W-1:0] inj_data);
        bit got_ready;
        r_lat = 0; r_en = 0; r_busy_low = 0; r_data = '0; r_err = 1'b0;
        r_bits = 2'b00; r_after = 2'b11;
        if (port) begin req1_op = op; req1_a = a; req1_b = b; req_valid = 2'b10; end
        else      begin req0_op = op; req0_a = a; req0_b = b; req_valid = 2'b01; end
        got_ready = 1'b0;
        for (int i = 0; i < 10 && !got_ready; i++) begin
            @(negedge clk);
            if (req_ready[port]) got_ready = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!got_ready) begin
            req_valid = 2'b00;
            check("req_ready_timeout", 32'(0), 32'(1));
            return;
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        for (int k = 1; k <= 20; k++) begin
            force_valid = (k == inj);
            force_data  = inj_data;
            @(negedge clk);
            if (alu_en) r_en++;
            if (!busy) r_busy_low++;
            if (rsp_valid != 2'b00) begin
                r_lat = k; r_data = rsp_data; r_err = rsp_err; r_bits = rsp_valid;
                break;
            end
            @(posedge clk); #1;
        end
        force_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        r_after = rsp_valid;
        @(posedge clk); #1;
    endtask

    int n_rsp, last_cyc, bad;

    initial begin
        rst = 1'b1; req_valid = 2'b11;
        req0_op = OP_ADD; req0_a = 32'd1; req0_b = 32'd2;
        req1_op = OP_SUB; req1_a = 32'd3; req1_b = 32'd4;
        alu_attached = 1'b1; force_valid = 1'b0; force_data = '0;

        vecs[0] = '{1'b0, OP_ADD, 32'd5,      32'd7,      32'd12,       1'b0, 3, 1};
        vecs[1] = '{1'b1, OP_DIV, 32'd9,      32'd0,      32'd0,        1'b1, 1, 0};
        vecs[2] = '{1'b1, OP_REM, 32'd9,      32'd0,      32'd0,        1'b1, 1, 0};
        vecs[3] = '{1'b1, OP_DIV, 32'd9,      32'd3,      32'd3,        1'b0, 3, 1};
        vecs[4] = '{1'b1, OP_REM, 32'd9,      32'd3,      32'd0,        1'b0, 3, 1};
        vecs[5] = '{1'b0, OP_SUB, 32'd10,     32'd3,      32'd7,        1'b0, 3, 1};
        vecs[6] = '{1'b1, OP_XOR, 32'hF0F0,   32'h0FF0,   32'h0000FF00, 1'b0, 3, 1};
        vecs[7] = '{1'b0, OP_MUL, 32'd6,      32'd7,      32'd42,       1'b0, 3, 1};

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_alu_en",    32'(alu_en),    32'(0));
        check("rst_busy",      32'(busy),      32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_data",  rsp_data,       32'(0));
        check("rst_rsp_err",   32'(rsp_err),   32'(0));
        check("rst_grant_id",  32'(grant_id),  32'(0));
        check("rst_alu_op",    32'(alu_op),    32'(0));
        check("rst_alu_a",     alu_a,          32'(0));
        check("rst_alu_b",     alu_b,          32'(0));
        @(posedge clk); #1;
        rst = 1'b0; req_valid = 2'b00;
        @(posedge clk); #1;

        // Single-request vectors.
        for (int v = 0; v < 8; v++) begin
            run_one(vecs[v].port, vecs[v].op, vecs[v].a, vecs[v].b, 0, '0);
            check($sformatf("v%0d_data", v),  r_data,             vecs[v].exp_data);
            check($sformatf("v%0d_err", v),   32'(r_err),         32'(vecs[v].exp_err));
            check($sformatf("v%0d_lat", v),   32'(r_lat),         32'(vecs[v].exp_lat));
            check($sformatf("v%0d_en", v),    32'(r_en),          32'(vecs[v].exp_en));
            check($sformatf("v%0d_rspv", v),  32'(r_bits),        vecs[v].port ? 32'd2 : 32'd1);
            check($sformatf("v%0d_pulse", v), 32'(r_after),       32'(0));
            check($sformatf("v%0d_busy", v),  32'(r_busy_low),    32'(0));
            check($sformatf("v%0d_grant", v), 32'(grant_id),      32'(vecs[v].port));
        end

        // Contention from reset: port 0 first, strict alternation every 4 cycles.
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        req0_op = OP_SUB; req0_a = 32'd10;   req0_b = 32'd3;
        req1_op = OP_XOR; req1_a = 32'hF0F0; req1_b = 32'h0FF0;
        req_valid = 2'b11;
        n_rsp = 0; last_cyc = 0;
        for (int c = 0; c < 60 && n_rsp < 6; c++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) begin
                check($sformatf("cont%0d_rspv", n_rsp), 32'(rsp_valid), (n_rsp % 2) ? 32'd2 : 32'd1);
                check($sformatf("cont%0d_data", n_rsp), rsp_data, (n_rsp % 2) ? 32'h0000FF00 : 32'd7);
                check($sformatf("cont%0d_grant", n_rsp), 32'(grant_id), 32'(n_rsp % 2));
                if (n_rsp > 0) check($sformatf("cont%0d_gap", n_rsp), 32'(c - last_cyc), 32'd4);
                last_cyc = c;
                n_rsp++;
                if (n_rsp == 6) req_valid = 2'b00;
            end
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        check("cont_count", 32'(n_rsp), 32'd6);
        repeat (2) @(posedge clk); #1;

        // Timeout: hung ALU, then valid exactly on the last waiting cycle.
        alu_attached = 1'b0;
        run_one(1'b0, OP_ADD, 32'd1, 32'd2, 0, '0);
        check("to_lat",  32'(r_lat),  32'd9);
        check("to_err",  32'(r_err),  32'd1);
        check("to_data", r_data,      32'd0);
        check("to_en",   32'(r_en),   32'd1);
        run_one(1'b0, OP_ADD, 32'd1, 32'd2, 8, 32'hAA);
        check("tob_lat",  32'(r_lat), 32'd9);
        check("tob_err",  32'(r_err), 32'd0);
        check("tob_data", r_data,     32'hAA);

        // Reset while waiting on the ALU.
        req0_op = OP_ADD; req0_a = 32'd5; req0_b = 32'd7; req_valid = 2'b01;
        bad = 1;
        for (int i = 0; i < 10 && bad != 0; i++) begin
            @(negedge clk);
            if (req_ready[0]) bad = 0;
            @(posedge clk); #1;
        end
        check("rmid_accept", 32'(bad), 32'd0);
        req_valid = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rmid_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rmid_alu_en",    32'(alu_en),    32'd0);
        check("rmid_busy",      32'(busy),      32'd0);
        check("rmid_rsp_data",  rsp_data,       32'd0);
        check("rmid_rsp_err",   32'(rsp_err),   32'd0);
        check("rmid_alu_a",     alu_a,          32'd0);
        check("rmid_alu_op",    32'(alu_op),    32'd0);
        @(posedge clk); #1;
        force_valid = 1'b1; force_data = 32'h55;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || busy) bad++;
            @(posedge clk); #1;
            force_valid = 1'b0;
        end
        check("rmid_late_valid", 32'(bad), 32'd0);
        alu_attached = 1'b1;
        run_one(1'b0, OP_ADD, 32'd5, 32'd7, 0, '0);
        check("rmid_next_data", r_data,       32'd12);
        check("rmid_next_err",  32'(r_err),   32'd0);
        check("rmid_next_lat",  32'(r_lat),   32'd3);
        check("rmid_next_rspv", 32'(r_bits),  32'd1);

        // Stale ALU valid while idle.
        force_valid = 1'b1; force_data = 32'h77;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid != 2'b00 || busy || alu_en) bad++;
            @(posedge clk); #1;
            if (i == 1) force_valid = 1'b0;
        end
        check("stale_ignored", 32'(bad), 32'd0);
        run_one(1'b1, OP_PASSB, 32'd1, 32'h1234, 0, '0);
        check("stale_next_data", r_data,      32'h1234);
        check("stale_next_rspv", 32'(r_bits), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
